stopwatch_controller: RTL

Sequencing controller for a chain of cascaded decade (BCD) digit counters, forming a start/stop/lap/clear stopwatch. A prescaler divides `clk` into count ticks. A four-state FSM decides when the digit chain advances, holds or clears, and when the displayed value freezes for a lap reading. The block sits between debounced, synchronised push-button pulses and the 7-segment display decoders.

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/stopwatch_if.sv | 29 ++
 rtl/stopwatch_bcd_digit.sv | 28 ++
 rtl/stopwatch_controller.sv | 117 +++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its BCD digit chain.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } sw_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int         BCD_W   = 4;

  // Prescaler width: $clog2 of the divide ratio, never narrower than one bit.
  function automatic int pre_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Button-pulse inputs and display-side outputs of the stopwatch controller.
interface stopwatch_if
  import stopwatch_pkg::*;
#(
  parameter int DIGITS = 4
);

  // Pulses are single-cycle strobes sampled on every rising clk edge; there is
  // no ready/acknowledge. Outputs are valid in every cycle outside reset.
  logic                      start_stop;
  logic                      lap;
  logic                      clear;
  logic [BCD_W*DIGITS-1:0]   count;
  logic [BCD_W*DIGITS-1:0]   display;
  logic                      running;
  logic                      overflow;
  sw_state_t                 state;

  modport master (
    output start_stop, lap, clear,
    input  count, display, running, overflow, state
  );

  modport slave (
    input  start_stop, lap, clear,
    output count, display, running, overflow, state
  );

endinterface

// File: rtl/stopwatch_bcd_digit.sv
// One decade counter of the stopwatch chain; carry feeds the next digit's enable.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  logic [BCD_W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= (r_q == BCD_MAX) ? '0 : r_q + 1'b1;
    end
  end

  assign q     = r_q;
  assign carry = en && (r_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_controller.sv
// Start/stop/lap/clear sequencing, count prescaler and cascaded BCD digit chain.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10
)(
  input  logic        clk,
  input  logic        rst,
  stopwatch_if.slave  sw
);

  localparam int             PW       = pre_width(TICK_DIV);
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

  sw_state_t               r_state;
  logic [PW-1:0]           r_pre;
  logic [BCD_W*DIGITS-1:0] r_lap;
  logic                    r_running;
  logic                    r_overflow;

  logic                    w_active;
  logic                    w_tick;
  logic                    w_clr;
  logic [DIGITS:0]         w_en;
  logic [BCD_W*DIGITS-1:0] w_count;

  assign w_active = (r_state == RUN) || (r_state == LAP);
  assign w_tick   = w_active && (r_pre == PRE_LAST);
  assign w_clr    = (r_state == PAUSE) && sw.clear;
  assign w_en[0]  = w_tick;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_clr),
      .en    (w_en[g]),
      .q     (w_count[g*BCD_W +: BCD_W]),
      .carry (w_en[g+1])
    );
  end

  // Prescaler holds in PAUSE so a resumed run loses no partial tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else begin
      case (r_state)
        RUN, LAP: r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
        PAUSE:    r_pre <= w_clr ? '0 : r_pre;
        default:  r_pre <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_lap      <= '0;
      r_running  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sw.start_stop) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          if (sw.start_stop) begin
            r_state   <= PAUSE;
            r_running <= 1'b0;
          end else if (sw.lap) begin
            r_state <= LAP;
            r_lap   <= w_count;
          end
        end
        LAP: begin
          if (sw.start_stop) begin
            r_state   <= PAUSE;
            r_running <= 1'b0;
          end else if (sw.lap) begin
            r_state <= RUN;
          end
        end
        PAUSE: begin
          if (sw.clear) begin
            r_state <= IDLE;
          end else if (sw.start_stop) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase

      // A wrap and a clear cannot coincide: wraps only happen in RUN/LAP.
      if (w_clr) begin
        r_overflow <= 1'b0;
      end else if (w_en[DIGITS]) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign sw.count    = w_count;
  assign sw.display  = (r_state == LAP) ? r_lap : w_count;
  assign sw.running  = r_running;
  assign sw.overflow = r_overflow;
  assign sw.state    = r_state;

endmodule
